// File: rtl/cvsd_integrator_if.sv
// cvsd_integrator_if: delta/run-detect inputs and reconstructed-sample outputs of the CVSD integrator
interface cvsd_integrator_if #(
    parameter int DATA_W = 12,
    parameter int STEP_W = 10
);
    logic                     V2;
    logic                     V3;
    logic                     MUTE;
    logic signed [DATA_W-1:0] EST;
    logic [STEP_W-1:0]        STEP;
    logic                     VALID;
    logic                     SAT;
    modport master (output V2, V3, MUTE, input EST, STEP, VALID, SAT);
    modport slave  (input V2, V3, MUTE, output EST, STEP, VALID, SAT);
endinterface

// File: rtl/cvsd_integrator.sv
// cvsd_integrator: syllabic step adaptation plus leaky, saturating integration of the CVSD delta stream
module cvsd_integrator #(
    parameter int DATA_W      = 12,
    parameter int STEP_W      = 10,
    parameter int STEP_MIN    = 8,
    parameter int STEP_MAX    = 512,
    parameter int STEP_INC    = 32,
    parameter int DECAY_SHIFT = 3,
    parameter int LEAK_SHIFT  = 5,
    parameter int WARMUP      = 4
) (
    input logic             CLOCK_DIV,
    input logic             RESET,
    cvsd_integrator_if.slave bus
);
    typedef enum logic {WARM, RUN} state_t;
    localparam int CNT_W = WARMUP > 2 ? $clog2(WARMUP) : 1;
    localparam logic [STEP_W:0] S_MIN = (STEP_W+1)'(STEP_MIN);
    localparam logic [STEP_W:0] S_MAX = (STEP_W+1)'(STEP_MAX);
    localparam logic [STEP_W:0] S_INC = (STEP_W+1)'(STEP_INC);
    localparam logic signed [DATA_W+1:0] T_MAX = (DATA_W+2)'(2**(DATA_W-1)-1);
    localparam logic signed [DATA_W+1:0] T_MIN = -T_MAX - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP-1);
    logic signed [DATA_W-1:0] est_q, est_d;
    logic [STEP_W-1:0]        step_q, step_d;
    logic                     sat_q, sat_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    state_t                   state_q, state_d;
    logic [STEP_W:0]          s_up, s_dn;
    logic signed [DATA_W+1:0] e_x, d_x, t;
    // Widened arithmetic keeps the step sum and the estimate update from wrapping before the clamps.
    always_comb begin
        s_up    = {1'b0, step_q} + S_INC;
        s_dn    = {1'b0, step_q} - ({1'b0, step_q} >> DECAY_SHIFT);
        e_x     = (DATA_W+2)'(est_q);
        d_x     = signed'((DATA_W+2)'(step_q));
        t       = e_x + (bus.V2 ? d_x : -d_x) - (e_x >>> LEAK_SHIFT);
        est_d   = t > T_MAX ? T_MAX[DATA_W-1:0] : t < T_MIN ? T_MIN[DATA_W-1:0] : t[DATA_W-1:0];
        sat_d   = t > T_MAX || t < T_MIN;
        step_d  = STEP_W'(bus.V3 ? (s_up > S_MAX ? S_MAX : s_up) : (s_dn < S_MIN ? S_MIN : s_dn));
        cnt_d   = state_q == WARM ? cnt_q + 1'b1 : cnt_q;
        state_d = state_q == WARM && cnt_q == CNT_LAST ? RUN : state_q;
        if (bus.MUTE) begin
            est_d   = '0;
            step_d  = STEP_W'(STEP_MIN);
            sat_d   = 1'b0;
            cnt_d   = '0;
            state_d = WARM;
        end
    end
    always_ff @(posedge CLOCK_DIV or negedge RESET) begin
        if (!RESET) begin
            est_q   <= '0;
            step_q  <= STEP_W'(STEP_MIN);
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= WARM;
        end else begin
            est_q   <= est_d;
            step_q  <= step_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end
    assign bus.EST   = est_q;
    assign bus.STEP  = step_q;
    assign bus.SAT   = sat_q;
    assign bus.VALID = state_q == RUN;
endmodule

// File: tb/tb_cvsd_integrator.sv
// tb_cvsd_integrator: directed vectors and corner sequences for the CVSD integrator
module tb_cvsd_integrator;
    logic CLOCK_DIV = 1'b0;
    logic RESET = 1'b0;
    cvsd_integrator_if bus ();
    cvsd_integrator dut (.CLOCK_DIV(CLOCK_DIV), .RESET(RESET), .bus(bus));
    always #5 CLOCK_DIV = ~CLOCK_DIV;

    typedef struct {
        bit rst;
        bit v2, v3, mute;
        int est, step;
        bit valid, sat;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int est_m, step_m, warm_m;
    bit sat_m;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input int est, input int step, input int valid, input int sat);
        chk({tag, "_est"}, int'(bus.EST), est);
        chk({tag, "_step"}, int'(bus.STEP), step);
        chk({tag, "_valid"}, int'(bus.VALID), valid);
        chk({tag, "_sat"}, int'(bus.SAT), sat);
    endtask

    task automatic do_reset();
        bus.V2 = 1'b0; bus.V3 = 1'b0; bus.MUTE = 1'b0;
        RESET = 1'b0;
        @(negedge CLOCK_DIV);
        chk_out("reset", 0, 8, 0, 0);
        RESET = 1'b1;
        est_m = 0; step_m = 8; warm_m = 0; sat_m = 0;
    endtask

    // Behavioural reference: estimate uses the pre-update step, outputs sampled 1 time unit after the edge.
    task automatic cyc(input bit v2, input bit v3, input bit mute);
        int t;
        bus.V2 = v2; bus.V3 = v3; bus.MUTE = mute;
        @(posedge CLOCK_DIV);
        #1;
        if (mute) begin
            est_m = 0; step_m = 8; sat_m = 0; warm_m = 0;
        end else begin
            t = est_m + (v2 ? step_m : -step_m) - (est_m >>> 5);
            sat_m = t > 2047 || t < -2048;
            est_m = t > 2047 ? 2047 : (t < -2048 ? -2048 : t);
            step_m = v3 ? ((step_m + 32 > 512) ? 512 : step_m + 32)
                        : ((step_m - (step_m >> 3) < 8) ? 8 : step_m - (step_m >> 3));
            if (warm_m < 4) warm_m++;
        end
        chk_out("mdl", est_m, step_m, int'(warm_m >= 4), int'(sat_m));
    endtask

    vec_t tbl [10];
    int dec [4];

    initial begin
        tbl[0] = '{1, 1, 0, 0,  8, 8, 0, 0};
        tbl[1] = '{0, 1, 0, 0, 16, 8, 0, 0};
        tbl[2] = '{0, 1, 0, 0, 24, 8, 0, 0};
        tbl[3] = '{0, 1, 0, 0, 32, 8, 1, 0};
        tbl[4] = '{1, 1, 0, 0,  8, 8, 0, 0};
        tbl[5] = '{0, 0, 0, 0,  0, 8, 0, 0};
        tbl[6] = '{0, 1, 0, 0,  8, 8, 0, 0};
        tbl[7] = '{0, 0, 0, 0,  0, 8, 1, 0};
        tbl[8] = '{0, 1, 0, 0,  8, 8, 1, 0};
        tbl[9] = '{0, 0, 0, 0,  0, 8, 1, 0};
        dec = '{448, 392, 343, 301};

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rst) do_reset();
            cyc(tbl[i].v2, tbl[i].v3, tbl[i].mute);
            chk_out($sformatf("vec%0d", i), tbl[i].est, tbl[i].step, int'(tbl[i].valid), int'(tbl[i].sat));
        end

        // Step ramp to the ceiling, then decay back to the floor.
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            cyc(n[0], 1'b1, 1'b0);
            chk($sformatf("ramp%0d", n), int'(bus.STEP), (8 + 32 * n > 512) ? 512 : 8 + 32 * n);
        end
        for (int n = 0; n < 4; n++) begin
            cyc(n[0], 1'b0, 1'b0);
            chk($sformatf("decay%0d", n), int'(bus.STEP), dec[n]);
        end
        for (int n = 0; n < 40; n++) cyc(n[0], 1'b0, 1'b0);
        chk("step_floor", int'(bus.STEP), 8);

        // Positive and negative saturation.
        do_reset();
        for (int n = 0; n < 30; n++) cyc(1'b1, 1'b1, 1'b0);
        chk("sat_pos_est", int'(bus.EST), 2047);
        chk("sat_pos_flag", int'(bus.SAT), 1);
        do_reset();
        for (int n = 0; n < 30; n++) cyc(1'b0, 1'b1, 1'b0);
        chk("sat_neg_est", int'(bus.EST), -2048);
        chk("sat_neg_flag", int'(bus.SAT), 1);

        // MUTE wins over V2/V3 and restarts warm-up.
        do_reset();
        for (int n = 0; n < 20; n++) cyc(n % 3 != 0, 1'b1, 1'b0);
        chk("pre_mute_step", int'(bus.STEP), 512);
        cyc(1'b1, 1'b1, 1'b1);
        chk_out("mute", 0, 8, 0, 0);
        for (int n = 1; n <= 4; n++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk($sformatf("rewarm%0d", n), int'(bus.VALID), int'(n == 4));
        end

        // Asynchronous reset between edges.
        for (int n = 0; n < 20; n++) cyc(1'b0, 1'b1, 1'b0);
        #2;
        RESET = 1'b0;
        #1;
        chk_out("async_rst", 0, 8, 0, 0);
        @(negedge CLOCK_DIV);
        RESET = 1'b1;
        est_m = 0; step_m = 8; warm_m = 0; sat_m = 0;
        cyc(1'b1, 1'b0, 1'b0);
        chk("post_rst_est", int'(bus.EST), 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
